// File: rtl/div_gen.sv
// div_gen: iterative restoring divider, signed or unsigned, one quotient bit
// per cycle, MSB first. Result packs {remainder, quotient}.
// Optional feature macro: DIV_GEN_EARLY_OUT_EN (short-circuits |dividend| < |divisor|).
// All outputs are registered from the next-state decode so they track the state.
module div_gen #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sign,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic               start,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement magnitude when signed mode sees a negative value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      mag = ~v + W_ONE;
    end else begin
      mag = v;
    end
  endfunction

  // Conditional two's-complement negation for the final sign fix-up.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    if (n) begin
      neg_if = ~v + W_ONE;
    end else begin
      neg_if = v;
    end
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [WIDTH-1:0]   quo_r, quo_s;
  logic [WIDTH-1:0]   rem_r, rem_s;
  logic [WIDTH-1:0]   dvs_r, dvs_s;
  logic               neg_q_r, neg_q_s;
  logic               neg_r_r, neg_r_s;
  logic [2*WIDTH-1:0] result_r, result_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic               div_zero_r, div_zero_s;

  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               early_s;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    a_mag_s    = mag(reg1, sign);
    b_mag_s    = mag(reg2, sign);
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = shifted_s - {1'b0, dvs_r};
    qbit_s     = ~trial_s[WIDTH];
    if (qbit_s) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      rem_step_s = shifted_s[WIDTH-1:0];
    end
    quo_step_s = {quo_r[WIDTH-2:0], qbit_s};
`ifdef DIV_GEN_EARLY_OUT_EN
    early_s    = (a_mag_s < b_mag_s);
`else
    early_s    = 1'b0;
`endif
  end

  // Next-state and next-output decode; result/done/div_zero are nonzero only in DONE.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    quo_s      = quo_r;
    rem_s      = rem_r;
    dvs_s      = dvs_r;
    neg_q_s    = neg_q_r;
    neg_r_s    = neg_r_r;
    result_s   = {(2*WIDTH){1'b0}};
    done_s     = 1'b0;
    busy_s     = 1'b0;
    div_zero_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !cancel) begin
          neg_q_s = sign & (reg1[WIDTH-1] ^ reg2[WIDTH-1]);
          neg_r_s = sign & reg1[WIDTH-1];
          quo_s   = a_mag_s;
          dvs_s   = b_mag_s;
          rem_s   = W_ZERO;
          cnt_s   = CNT_ZERO;
          if (reg2 == W_ZERO) begin
            state_s = ZERO;
            busy_s  = 1'b1;
          end else if (early_s) begin
            state_s  = DONE;
            done_s   = 1'b1;
            result_s = {reg1, W_ZERO};
          end else begin
            state_s = CALC;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ZERO: begin
        if (cancel) begin
          state_s = IDLE;
        end else begin
          state_s    = DONE;
          done_s     = 1'b1;
          div_zero_s = 1'b1;
        end
      end
      CALC: begin
        if (cancel) begin
          state_s = IDLE;
        end else begin
          rem_s = rem_step_s;
          quo_s = quo_step_s;
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s  = DONE;
            done_s   = 1'b1;
            result_s = {neg_if(rem_step_s, neg_r_r), neg_if(quo_step_s, neg_q_r)};
          end else begin
            busy_s = 1'b1;
          end
        end
      end
      DONE: begin
        if (cancel || !start) begin
          state_s = IDLE;
        end else begin
          done_s     = 1'b1;
          result_s   = result_r;
          div_zero_s = div_zero_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      quo_r      <= W_ZERO;
      rem_r      <= W_ZERO;
      dvs_r      <= W_ZERO;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      result_r   <= {(2*WIDTH){1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      quo_r      <= quo_s;
      rem_r      <= rem_s;
      dvs_r      <= dvs_s;
      neg_q_r    <= neg_q_s;
      neg_r_r    <= neg_r_s;
      result_r   <= result_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      div_zero_r <= div_zero_s;
    end
  end

  assign result   = result_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_div_gen.sv
// Directed self-checking bench for div_gen at WIDTH=32.
// Cycle k is the clock period that ends on the k-th rising edge after the
// capture edge; inputs are driven and outputs sampled 1 ns after a rising edge.
module tb_div_gen;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           sign;
  logic [W-1:0]   reg1;
  logic [W-1:0]   reg2;
  logic           start;
  logic           cancel;
  logic [2*W-1:0] result;
  logic           done;
  logic           busy;
  logic           div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  div_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sign(sign), .reg1(reg1), .reg2(reg2),
    .start(start), .cancel(cancel), .result(result), .done(done),
    .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    sign  = s;
    reg1  = a;
    reg2  = b;
    start = 1'b1;
  endtask

  // Steps until done (bounded); lat = cycle number of first done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sign = 1'b0; reg1 = '0; reg2 = '0; start = 1'b0; cancel = 1'b0;
    #3;
    n_cmp++;
    if ({result, done, busy, div_zero} !== {64'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b expected 0/000", result, done, busy, div_zero);
    end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    issue(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 33; c++) begin
      logic [1:0] exp_bd;
      step();
      if (c == 1) begin
        reg1 = 32'h0; reg2 = 32'h0; sign = 1'b1;
      end
      exp_bd = (c <= 32) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({busy, done} !== exp_bd) begin
        n_bad++;
        $display("FAIL u100_7_timing cycle %0d: got busy/done %b%b expected %b", c, busy, done, exp_bd);
      end
    end
    n_cmp++;
    if ({result, div_zero} !== {64'h00000002_0000000E, 1'b0}) begin
      n_bad++;
      $display("FAIL u100_7_result: got %h dz %b expected 000000020000000e dz 0", result, div_zero);
    end
    step(); step();
    n_cmp++;
    if ({result, done} !== {64'h00000002_0000000E, 1'b1}) begin
      n_bad++;
      $display("FAIL u100_7_hold: got %h done %b expected 000000020000000e done 1", result, done);
    end
    start = 1'b0;
    step();
    n_cmp++;
    if ({result, done, busy} !== {64'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL u100_7_release: got %h done %b busy %b expected 0 0 0", result, done, busy);
    end
  endtask

  task automatic test_signed();
    logic           s_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0]   a_v [5] = '{32'hFFFFFFF9, 32'h80000000, 32'h00000007, 32'hFFFFFFF8, 32'hFFFFFFF9};
    logic [W-1:0]   b_v [5] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000002};
    logic [2*W-1:0] e_v [5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000,
                                64'h00000001_FFFFFFFD, 64'hFFFFFFFE_00000002,
                                64'h00000001_7FFFFFFC};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(s_v[i], a_v[i], b_v[i]);
      wait_done(lat);
      n_cmp++;
      if (lat != 33 || result !== e_v[i] || div_zero !== 1'b0) begin
        n_bad++;
        $display("FAIL signed_vec%0d: got lat %0d result %h dz %b expected lat 33 result %h dz 0",
                 i, lat, result, div_zero, e_v[i]);
      end
      start = 1'b0;
      step();
    end
  endtask

  task automatic test_div_zero();
    issue(1'b0, 32'h1234, 32'h0);
    step();
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL dz_cycle1: got busy/done %b%b expected 10", busy, done);
    end
    step();
    n_cmp++;
    if ({result, done, busy, div_zero} !== {64'h0, 3'b101}) begin
      n_bad++;
      $display("FAIL dz_cycle2: got %h %b%b%b expected 0 101", result, done, busy, div_zero);
    end
    start = 1'b0;
    step();
    n_cmp++;
    if ({done, busy, div_zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL dz_release: got %b%b%b expected 000", done, busy, div_zero);
    end
  endtask

  task automatic test_cancel();
    int lat;
    issue(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      step();
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_bad++;
        $display("FAIL cancel_pre cycle %0d: got busy/done %b%b expected 10", c, busy, done);
      end
    end
    cancel = 1'b1;
    start  = 1'b0;
    step();
    n_cmp++;
    if ({busy, done, result} !== {2'b00, 64'h0}) begin
      n_bad++;
      $display("FAIL cancel_idle: got busy/done %b%b result %h expected 00 0", busy, done, result);
    end
    cancel = 1'b0;
    issue(1'b0, 32'd9, 32'd3);
    wait_done(lat);
    n_cmp++;
    if (lat != 33 || result !== 64'h00000000_00000003) begin
      n_bad++;
      $display("FAIL cancel_restart: got lat %0d result %h expected lat 33 result 0000000000000003", lat, result);
    end
    cancel = 1'b1;
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL cancel_in_done: got done/busy %b%b expected 00", done, busy);
    end
    cancel = 1'b0;
    start  = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 15; c++) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_busy: got %b expected 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({result, done, busy, div_zero} !== {64'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %h %b%b%b expected 0 000", result, done, busy, div_zero);
    end
    start = 1'b0;
    #1;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got done/busy %b%b expected 00", done, busy);
    end
    issue(1'b0, 32'hFFFFFFFF, 32'h00000010);
    wait_done(lat);
    n_cmp++;
    if (lat != 33 || result !== 64'h0000000F_0FFFFFFF) begin
      n_bad++;
      $display("FAIL rst_mid_next: got lat %0d result %h expected lat 33 result 0000000f0fffffff", lat, result);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_early_out();
    int lat;
    int exp_lat;
`ifdef DIV_GEN_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    issue(1'b0, 32'd3, 32'd10);
    wait_done(lat);
    n_cmp++;
    if (lat != exp_lat || result !== 64'h00000003_00000000 || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL early_u3_10: got lat %0d result %h dz %b expected lat %0d result 0000000300000000 dz 0",
               lat, result, div_zero, exp_lat);
    end
    start = 1'b0;
    step();
    issue(1'b1, 32'hFFFFFFFD, 32'd10);
    wait_done(lat);
    n_cmp++;
    if (lat != exp_lat || result !== 64'hFFFFFFFD_00000000) begin
      n_bad++;
      $display("FAIL early_s-3_10: got lat %0d result %h expected lat %0d result fffffffd00000000",
               lat, result, exp_lat);
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_early_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
